// File: rtl/escalonador_comparador_5bits.sv
// Two-requester round-robin scheduler sharing one serial (LSB-first) 1-bit XOR comparator.
// Define COMPARE_EARLY_EXIT_EN to finish a compare at the first differing bit.
module escalonador_comparador_5bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [4:0] a0,
    input  logic [4:0] b0,
    input  logic       req1,
    input  logic [4:0] a1,
    input  logic [4:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done0,
    output logic       done1,
    output logic       result
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

`ifdef COMPARE_EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       acc_q, acc_d;
    logic       ptr_q, ptr_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       result_q, result_d;
    logic [4:0] a_q, a_d;
    logic [4:0] b_q, b_d;

    logic       win1;
    logic       bit_diff;
    logic       last_bit;

    // Requester 1 wins when alone, or when both ask and the pointer favours it.
    assign win1     = req1 && (!req0 || ptr_q);
    assign bit_diff = a_q[cnt_q] ^ b_q[cnt_q];
    assign last_bit = (cnt_q == 3'd4) || (EarlyExit && bit_diff);

    // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ptr_d    = ptr_q;
        gnt0_d   = gnt0_q;
        gnt1_d   = gnt1_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = COMPARE;
                    a_d     = win1 ? a1 : a0;
                    b_d     = win1 ? b1 : b0;
                    gnt0_d  = !win1;
                    gnt1_d  = win1;
                    cnt_d   = 3'd0;
                    acc_d   = 1'b0;
                end
            end
            COMPARE: begin
                acc_d = acc_q | bit_diff;
                cnt_d = cnt_q + 3'd1;
                if (last_bit) begin
                    state_d  = DONE;
                    result_d = acc_q | bit_diff;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                ptr_d   = gnt0_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            acc_q    <= 1'b0;
            ptr_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ptr_q    <= ptr_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            result_q <= result_d;
        end
    end

    // NOTE: operand latches are pure datapath, always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign busy   = (state_q != IDLE);
    assign done0  = (state_q == DONE) && gnt0_q;
    assign done1  = (state_q == DONE) && gnt1_q;
    assign result = result_q;

endmodule

// File: doc/escalonador_comparador_5bits.md
ESCALONADOR_COMPARADOR_5BITS -- requirements
Module: escalonador_comparador_5bits

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have the port req0, input, 1 bit: requester 0 asks for a 5-bit inequality compare.
REQ-004 The block SHALL have the ports a0 and b0, input, 5 bits each: requester 0 operands.
REQ-005 The block SHALL have the port req1, input, 1 bit: requester 1 asks for a compare.
REQ-006 The block SHALL have the ports a1 and b1, input, 5 bits each: requester 1 operands.
REQ-007 The block SHALL have the ports gnt0 and gnt1, output, 1 bit each: registered grant, high for the whole transaction of the owning requester.
REQ-008 The block SHALL have the port busy, output, 1 bit: high in any state other than IDLE.
REQ-009 The block SHALL have the ports done0 and done1, output, 1 bit each: one-cycle completion pulse to the owning requester.
REQ-010 The block SHALL have the port result, output, 1 bit: 1 when the operands differ, 0 when they are equal; valid while done0 or done1 is high.

Function
REQ-011 The block SHALL share one 1-bit XOR comparator cell, used serially LSB-first, between the two requesters; it SHALL NOT use a parallel 5-bit datapath.
REQ-012 FSM states SHALL be IDLE, COMPARE and DONE.
REQ-013 IDLE with at least one req high: at the edge, the block SHALL pick a winner, latch its a and b into internal registers, set its gnt, clear the bit counter and the accumulator, and enter COMPARE.
REQ-014 Arbitration SHALL be round-robin: when only one req is high, that requester wins.
REQ-015 When req0 and req1 are both high, the requester indicated by the priority pointer SHALL win; the pointer resets to 0.
REQ-016 On every exit from DONE, the priority pointer SHALL point to the requester that was not just served.
REQ-017 In COMPARE, each edge SHALL update acc := acc OR (a[cnt] XOR b[cnt]) and cnt := cnt+1; at the edge that processes cnt=4 the state SHALL become DONE.
REQ-018 Baseline latency: grant edge E0, bits processed at E1..E5, done high during the cycle after E5, state back to IDLE at E6.
REQ-019 In DONE, done of the granted requester SHALL be 1 for exactly one cycle and result SHALL equal acc.
REQ-020 result SHALL hold its value until the next DONE.
REQ-021 gnt SHALL fall at the exit from DONE.
REQ-022 Operand inputs SHALL be ignored after latching; a change mid-transaction SHALL NOT affect result.
REQ-023 Dropping req during COMPARE SHALL NOT abort the transaction; done still pulses.
REQ-024 A req held high through DONE SHALL be treated as a new request in IDLE, subject to the updated priority; there SHALL be at least one IDLE cycle between transactions.
REQ-025 gnt0 and gnt1 SHALL never be high together, and done0 and done1 SHALL never be high together.

Reset
REQ-026 When rst_n is low, the block SHALL immediately force state to IDLE and set cnt, acc, the priority pointer, gnt0, gnt1, busy, done0, done1 and result to 0, regardless of the current state.
REQ-027 A reset mid-transaction SHALL discard the transaction with no done pulse; after rst_n rises, the first edge SHALL behave as IDLE.

Configuration
REQ-028 The macro COMPARE_EARLY_EXIT_EN SHALL control early exit.
REQ-029 With COMPARE_EARLY_EXIT_EN defined: when the XOR of bit k is 1, the block SHALL set acc, enter DONE at that same edge E(k+1) and skip the remaining bits.
REQ-030 With COMPARE_EARLY_EXIT_EN undefined: all 5 bits SHALL always be processed and latency SHALL be fixed per REQ-018.
REQ-031 Equal operands SHALL take full latency in both builds.

Verification
REQ-032 The bench SHALL drive req0=1, a0=01010, b0=00101 -> required: gnt0 at E0, done0 after E5 with result=1; with EN defined, done0 after E1 instead.
REQ-033 The bench SHALL drive req1=1, a1=01100, b1=01100 -> required: done1 after E5 with result=0 in both builds.
REQ-034 The bench SHALL hold req0 and req1 both high, with a0/b0=00001/00000 and a1/b1=00011/00011 -> required: requester 0 served first with result=1, then requester 1 with result=0, then requester 0 again.
REQ-035 The bench SHALL start req0 with 10000/00000, change a0 to 00000 at E2 and drop req0 at E3 -> required: done0 still pulses with result=1.
REQ-036 The bench SHALL pull rst_n low at E3 of a transaction -> required: gnt, busy and done fall immediately, no done pulse follows, and the next simultaneous request goes to requester 0.
